// File: rtl/hexout_pkg.sv
// -----------------------------------------------------------------------------
// hexout_pkg
// Shared constants for the multiplexed hex display driver.
//   GLYPH_TABLE : 16 logical segment patterns, lit-high, bit0 = segment a,
//                 bit6 = segment g. Index 0..15 is the hex digit shown.
//                 b and d are lowercase, A C E F uppercase.
//   BLANK_SEGS  : logical pattern with every segment dark.
// Output polarity is applied by the user of these constants, not here.
// -----------------------------------------------------------------------------
package hexout_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] BLANK_SEGS = 7'b0000000;

    // Concatenation lists entry 15 first so that GLYPH_TABLE[n] is digit n.
    localparam logic [15:0][SEG_W-1:0] GLYPH_TABLE = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

endpackage

// File: rtl/hex7_decode.sv
// -----------------------------------------------------------------------------
// hex7_decode
// Combinational nibble to seven-segment decoder producing the logical
// (lit-high) pattern. The parent applies the board polarity.
// Ports:
//   nibble in  4 : hex value to show
//   segs   out 7 : logical segments, bit0 = a ... bit6 = g
// -----------------------------------------------------------------------------
module hex7_decode
    import hexout_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] segs
);

    assign segs = GLYPH_TABLE[nibble];

endmodule

// File: rtl/hexout_scan.sv
// -----------------------------------------------------------------------------
// hexout_scan
// Multiplexed common-anode hex display driver. Scans DIGITS digits from a
// packed nibble word, leftmost digit (DIGITS-1) first. Each digit slot lasts
// 2^BRIGHT_W scan ticks; the anode is on for phases p <= brightness, giving
// PWM dimming. The word and decimal points are captured once per frame so a
// frame never mixes old and new nibbles.
//
// Optional feature: define HEXOUT_SCAN_LZB_EN to blank leading zero digits
// (digit 0 is never blanked). Without it, every digit is always shown.
//
// Ports:
//   clk        in  1         : clock
//   reset      in  1         : asynchronous, active-high reset
//   clken      in  1         : scan tick, one clk wide (may be held high)
//   word       in  4*DIGITS  : nibble i drives digit i
//   dp_in      in  DIGITS    : bit i lights the decimal point of digit i
//   brightness in  BRIGHT_W  : duty select, sampled every tick
//   seg        out 7         : registered segments, bit0 = a ... bit6 = g
//   an         out DIGITS    : registered digit enables, bit i = digit i
//   dp         out 1         : registered decimal point
//   frame      out 1         : one-clk pulse on the first tick of a frame
// -----------------------------------------------------------------------------
module hexout_scan
    import hexout_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int BRIGHT_W       = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic [4*DIGITS-1:0]   word,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [SEG_W-1:0]      seg,
    output logic [DIGITS-1:0]     an,
    output logic                  dp,
    output logic                  frame
);

    localparam int              DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0]   D_TOP   = DW'(DIGITS - 1);
    localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? ~BLANK_SEGS : BLANK_SEGS;
    localparam logic [DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic            DP_OFF  = SEG_ACTIVE_LOW;

    // Scan state
    logic [DW-1:0]       d;
    logic [BRIGHT_W-1:0] p;
    logic [4*DIGITS-1:0] shadow_word;
    logic [DIGITS-1:0]   shadow_dp;

    // Next-state / decode signals
    logic                frame_start;
    logic [4*DIGITS-1:0] cur_word;
    logic [DIGITS-1:0]   cur_dp;
    logic [3:0]          nibble;
    logic                dp_sel;
    logic [DIGITS-1:0]   an_sel;
    logic                digit_blank;
    logic                lit;
    logic [SEG_W-1:0]    glyph_segs;
    logic [SEG_W-1:0]    seg_logic;
    logic [DW-1:0]       d_next;
    logic [BRIGHT_W-1:0] p_next;
    logic [SEG_W-1:0]    seg_next;
    logic [DIGITS-1:0]   an_next;
    logic                dp_next;

    // The frame-start tick decodes from the value being captured this very
    // tick, so it bypasses the shadow registers.
    assign frame_start = (d == D_TOP) && (p == '0);
    assign cur_word    = frame_start ? word  : shadow_word;
    assign cur_dp      = frame_start ? dp_in : shadow_dp;

    // Select the current digit's nibble, dp bit and anode one-hot.
    always_comb begin
        nibble = 4'h0;
        dp_sel = 1'b0;
        an_sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (d == DW'(i)) begin
                nibble    = cur_word[4*i +: 4];
                dp_sel    = cur_dp[i];
                an_sel[i] = 1'b1;
            end
        end
    end

`ifdef HEXOUT_SCAN_LZB_EN
    // A digit above 0 is a leading zero when it and every higher nibble are 0.
    always_comb begin
        digit_blank = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if ((d == DW'(i)) && ((cur_word >> (4*i)) == '0)) begin
                digit_blank = 1'b1;
            end
        end
    end
`else
    assign digit_blank = 1'b0;
`endif

    hex7_decode u_decode (
        .nibble (nibble),
        .segs   (glyph_segs)
    );

    // Segments and dp are only driven while the anode is on to avoid ghosting.
    assign lit       = (p <= brightness) && !digit_blank;
    assign seg_logic = lit ? glyph_segs : BLANK_SEGS;
    assign seg_next  = SEG_ACTIVE_LOW ? ~seg_logic : seg_logic;
    assign an_next   = lit ? (AN_ACTIVE_LOW ? ~an_sel : an_sel) : AN_OFF;
    assign dp_next   = SEG_ACTIVE_LOW ? ~(lit & dp_sel) : (lit & dp_sel);

    // Phase wraps naturally; digit steps down on phase wrap, 0 -> DIGITS-1.
    assign p_next = p + BRIGHT_W'(1);
    always_comb begin
        d_next = d;
        if (&p) begin
            d_next = (d == '0) ? D_TOP : (d - DW'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d           <= D_TOP;
            p           <= '0;
            shadow_word <= '0;
            shadow_dp   <= '0;
        end else if (clken) begin
            d <= d_next;
            p <= p_next;
            if (frame_start) begin
                shadow_word <= word;
                shadow_dp   <= dp_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg   <= SEG_OFF;
            an    <= AN_OFF;
            dp    <= DP_OFF;
            frame <= 1'b0;
        end else if (clken) begin
            seg   <= seg_next;
            an    <= an_next;
            dp    <= dp_next;
            frame <= frame_start;
        end else begin
            frame <= 1'b0;
        end
    end

endmodule
